// File: rtl/test_controller_pkg.sv
// Shared constants for the test controller and the core it supervises.
// State encoding, tohost address and the tohost pass code live here.
package test_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;
  localparam logic [31:0] TOHOST_PASS         = 32'd1;
  localparam int          RESET_CNT_W         = 16;

endpackage

// File: rtl/cycle_counter.sv
// 32-bit saturating cycle counter with synchronous clear and count enable.
// Single cycle; clear has priority over enable.
module cycle_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_enable,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != 32'hFFFF_FFFF)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/test_controller.sv
// Sequences a core through reset and run, ending on a tohost store or cycle budget.
// All outputs registered; state changes are visible one cycle after their trigger.
module test_controller
  import test_controller_pkg::*;
#(
  parameter int          TIMEOUT      = 5000,
  parameter int          RESET_CYCLES = 2,
  parameter logic [31:0] TOHOST_ADDR  = TOHOST_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [31:0] gp_value,
  output logic        core_rst,
  output logic        running,
  output logic        done,
  output logic        passed,
  output logic        timed_out,
  output logic [30:0] fail_test,
  output logic [31:0] cycle_count
);

  localparam logic [31:0]            TO_LAST = 32'(TIMEOUT - 1);
  localparam logic [RESET_CNT_W-1:0] RC_LAST = RESET_CNT_W'(RESET_CYCLES - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [RESET_CNT_W-1:0] r_rst_cnt;
  logic                   r_core_rst;
  logic                   r_running;
  logic                   r_done;
  logic                   r_passed;
  logic                   r_timed_out;
  logic [30:0]            r_fail_test;
  logic [31:0]            w_count;
  logic                   w_start_ok;
  logic                   w_tohost_hit;
  logic                   w_timeout;

  assign w_start_ok   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_tohost_hit = st_valid && (st_addr == TOHOST_ADDR) && (st_data != 32'd0);
  assign w_timeout    = (w_count == TO_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_next = ST_RESET;
      ST_RESET:         if (r_rst_cnt == RC_LAST) w_next = ST_RUN;
      ST_RUN:           if (w_tohost_hit || w_timeout) w_next = ST_DONE;
      default:          w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_rst_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_rst_cnt <= (r_state == ST_RESET) ? r_rst_cnt + 1'b1 : '0;
    end
  end

  // Status flags follow the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_core_rst  <= 1'b1;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_passed    <= 1'b0;
      r_timed_out <= 1'b0;
      r_fail_test <= '0;
    end else begin
      r_core_rst <= (w_next != ST_RUN);
      r_running  <= (w_next == ST_RUN);
      r_done     <= (w_next == ST_DONE);
      if (w_start_ok) begin
        r_passed    <= 1'b0;
        r_timed_out <= 1'b0;
        r_fail_test <= '0;
      end else if ((r_state == ST_RUN) && w_tohost_hit) begin
        r_passed    <= (st_data == TOHOST_PASS);
        r_timed_out <= 1'b0;
        r_fail_test <= (st_data == TOHOST_PASS) ? 31'd0 : st_data[31:1];
      end else if ((r_state == ST_RUN) && w_timeout) begin
        r_passed    <= (gp_value == TOHOST_PASS);
        r_timed_out <= 1'b1;
        r_fail_test <= '0;
      end
    end
  end

  cycle_counter u_cycle_counter (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_start_ok),
    .i_enable (r_state == ST_RUN),
    .o_count  (w_count)
  );

  assign core_rst    = r_core_rst;
  assign running     = r_running;
  assign done        = r_done;
  assign passed      = r_passed;
  assign timed_out   = r_timed_out;
  assign fail_test   = r_fail_test;
  assign cycle_count = w_count;

endmodule

// File: tb/tb_test_controller.sv
// Randomized bench for test_controller; expectations derived per run from the stimulus plan.
module tb_test_controller;

  localparam int          TIMEOUT = 100;
  localparam int          RC      = 2;
  localparam logic [31:0] TOHOST  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [31:0] gp_value;
  logic        core_rst;
  logic        running;
  logic        done;
  logic        passed;
  logic        timed_out;
  logic [30:0] fail_test;
  logic [31:0] cycle_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  test_controller #(.TIMEOUT(TIMEOUT), .RESET_CYCLES(RC), .TOHOST_ADDR(TOHOST)) dut (
    .clk(clk), .rst(rst), .start(start), .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .gp_value(gp_value), .core_rst(core_rst), .running(running),
    .done(done), .passed(passed), .timed_out(timed_out), .fail_test(fail_test),
    .cycle_count(cycle_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".core_rst"}, 32'(core_rst), 32'd1);
    check({tag, ".running"}, 32'(running), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".passed"}, 32'(passed), 32'd0);
    check({tag, ".timed_out"}, 32'(timed_out), 32'd0);
    check({tag, ".fail_test"}, {1'b0, fail_test}, 32'd0);
    check({tag, ".cycle_count"}, cycle_count, 32'd0);
  endtask

  function automatic logic [31:0] rand_other_addr();
    logic [31:0] a = $urandom;
    if (a == TOHOST) a = a ^ 32'h4;
    return a;
  endfunction

  // One full test run: start pulse, reset phase, run phase, then a few DONE cycles.
  // hit_at: run-cycle index of the tohost store (>= TIMEOUT means none);
  // zero_at: run-cycle index of a tohost store carrying 0.
  task automatic do_run(input int hit_at, input logic [31:0] hit_data,
                        input logic [31:0] gp, input int zero_at);
    bit          hit;
    int          end_k;
    logic [31:0] exp_pass, exp_to, exp_fail;
    hit      = (hit_at < TIMEOUT) && (hit_data != 32'd0);
    end_k    = hit ? hit_at : TIMEOUT - 1;
    exp_to   = hit ? 32'd0 : 32'd1;
    exp_pass = hit ? 32'(hit_data == 32'd1) : 32'(gp == 32'd1);
    exp_fail = (hit && hit_data != 32'd1) ? (hit_data >> 1) : 32'd0;

    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < RC; i++) begin
      start    = 1'($urandom_range(0, 1));
      st_valid = 1'b0;
      check("rst_phase.core_rst", 32'(core_rst), 32'd1);
      check("rst_phase.running", 32'(running), 32'd0);
      check("rst_phase.done", 32'(done), 32'd0);
      check("rst_phase.passed", 32'(passed), 32'd0);
      check("rst_phase.fail", {1'b0, fail_test}, 32'd0);
      check("rst_phase.count", cycle_count, 32'd0);
      @(negedge clk);
    end
    for (int k = 0; k <= end_k; k++) begin
      check("run.running", 32'(running), 32'd1);
      check("run.core_rst", 32'(core_rst), 32'd0);
      check("run.done", 32'(done), 32'd0);
      check("run.count", cycle_count, 32'(k));
      start    = 1'($urandom_range(0, 1));
      gp_value = (k == TIMEOUT - 1) ? gp : $urandom;
      if (k == hit_at) begin
        st_valid = 1'b1; st_addr = TOHOST; st_data = hit_data;
      end else if (k == zero_at) begin
        st_valid = 1'b1; st_addr = TOHOST; st_data = 32'd0;
      end else begin
        st_valid = 1'($urandom_range(0, 1)); st_addr = rand_other_addr(); st_data = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check("done.done", 32'(done), 32'd1);
      check("done.running", 32'(running), 32'd0);
      check("done.core_rst", 32'(core_rst), 32'd1);
      check("done.passed", 32'(passed), exp_pass);
      check("done.timed_out", 32'(timed_out), exp_to);
      check("done.fail_test", {1'b0, fail_test}, exp_fail);
      check("done.count", cycle_count, 32'(end_k + 1));
      st_valid = 1'($urandom_range(0, 1));
      st_addr  = (j == 1) ? TOHOST : rand_other_addr();
      st_data  = $urandom;
      gp_value = $urandom;
      @(negedge clk);
    end
    st_valid = 1'b0;
  endtask

  task automatic reset_mid_run(input int k_stop);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (RC + k_stop) @(negedge clk);
    check("mid.running_before", 32'(running), 32'd1);
    rst   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check_reset_values("mid_rst");
    rst   = 1'b1;
    start = 1'b0;
    repeat (RC + 2) @(negedge clk);
    check("mid.idle_running", 32'(running), 32'd0);
    check("mid.idle_core_rst", 32'(core_rst), 32'd1);
    check("mid.idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; st_valid = 1'b0;
    st_addr = '0; st_data = '0; gp_value = '0;
    @(negedge clk);
    check_reset_values("por");
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("idle");

    do_run(40, 32'd1, 32'd0, 200);
    do_run(40, 32'd7, 32'd1, 200);
    do_run(500, 32'd0, 32'd1, 200);
    do_run(500, 32'd0, 32'd5, 200);
    do_run(TIMEOUT - 1, 32'd1, 32'd5, 200);
    do_run(30, 32'd1, 32'd0, 10);
    do_run(200, 32'd0, 32'd5, TIMEOUT - 1);
    do_run(20, 32'd0, 32'd1, 5);
    reset_mid_run(25);
    do_run(12, 32'hFFFF_FFFE, 32'd0, 3);

    for (int r = 0; r < 15; r++) begin
      int          h, z;
      logic [31:0] d;
      h = $urandom_range(0, 130);
      z = $urandom_range(0, 130);
      case ($urandom_range(0, 3))
        0:       d = 32'd1;
        1:       d = 32'd0;
        default: d = $urandom;
      endcase
      do_run(h, d, 32'($urandom_range(0, 2)), z);
      if (r == 7) reset_mid_run($urandom_range(0, TIMEOUT - 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
